// File: rtl/wavegen_pkg.sv
// Shared types and elaboration-time step tables for the sawtooth waveform writer.
// The step tables are computed once at elaboration, so no runtime divider is built.
package wavegen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          DUTY_MAX = 10;
  localparam logic [15:0] PEAK     = 16'hFFFF;
  localparam int          SEL_W    = 4;
  localparam int          STEP_W   = 24;
  localparam int          FRAC_W   = 8;
  localparam int          STEP_NUM = 65535 * 256;

  typedef struct packed {
    logic [31:0]       rise_len;
    logic [STEP_W-1:0] up_step;
    logic [STEP_W-1:0] down_step;
  } step_entry_t;

  typedef step_entry_t [DUTY_MAX:0] step_tbl_t;

  function automatic int rise_len(input int sel, input int n);
    return (sel * n + 5) / 10;
  endfunction

  function automatic logic [STEP_W-1:0] up_step(input int r);
    if (r <= 0) return '0;
    return STEP_W'(STEP_NUM / r);
  endfunction

  // A full-length rise (sel=10) has no falling segment, so its step is left at zero.
  function automatic logic [STEP_W-1:0] down_step(input int n, input int r);
    if (n - r <= 0) return '0;
    return STEP_W'(STEP_NUM / (n - r));
  endfunction

  function automatic step_tbl_t build_step_tbl(input int n);
    step_tbl_t tbl;
    for (int s = 0; s <= DUTY_MAX; s++) begin
      tbl[s].rise_len  = 32'(rise_len(s, n));
      tbl[s].up_step   = up_step(rise_len(s, n));
      tbl[s].down_step = down_step(n, rise_len(s, n));
    end
    return tbl;
  endfunction

  // Out-of-range duty selects collapse to the all-zero table.
  function automatic logic [SEL_W-1:0] sel_norm(input logic [SEL_W-1:0] sel);
    return (int'(sel) > DUTY_MAX) ? '0 : sel;
  endfunction

endpackage

// File: rtl/sawtooth_step_rom.sv
// Combinational lookup of rise length and 16.8 fixed-point up/down steps per duty select.
module sawtooth_step_rom
  import wavegen_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [SEL_W-1:0]  i_sel,
  output logic [ADDR_W:0]   o_rise_len,
  output logic [STEP_W-1:0] o_up_step,
  output logic [STEP_W-1:0] o_down_step
);

  localparam step_tbl_t STEP_TBL = build_step_tbl(1 << ADDR_W);

  logic [SEL_W-1:0] idx;

  assign idx = sel_norm(i_sel);

  always_comb begin
    o_rise_len  = (ADDR_W + 1)'(STEP_TBL[idx].rise_len);
    o_up_step   = STEP_TBL[idx].up_step;
    o_down_step = STEP_TBL[idx].down_step;
  end

endmodule

// File: rtl/sawtooth_lut_writer.sv
// Writes one asymmetric sawtooth table (rise then fall) into a waveform RAM,
// one address/data beat per accepted valid/ready handshake.
module sawtooth_lut_writer
  import wavegen_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_wready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_done
);

  localparam int                ACC_W     = DATA_W + FRAC_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ACC_W-1:0]  ACC_PEAK  = ACC_W'({PEAK, {FRAC_W{1'b0}}});

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               active_q;
  logic               done_q;

  logic [ADDR_W:0]    r_len;
  logic [STEP_W-1:0]  up_inc;
  logic [STEP_W-1:0]  down_dec;
  logic [ADDR_W:0]    addr_inc;
  logic               beat;

  sawtooth_step_rom #(
    .ADDR_W (ADDR_W)
  ) u_step_rom (
    .i_sel       (sel_q),
    .o_rise_len  (r_len),
    .o_up_step   (up_inc),
    .o_down_step (down_dec)
  );

  assign beat     = active_q && i_wready;
  assign addr_inc = {1'b0, addr_q} + (ADDR_W + 1)'(1);

  // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RISE;
          sel_d   = sel_norm(i_sel);
          addr_d  = '0;
          acc_d   = '0;
        end
      end
      RISE: begin
        if (beat) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d = addr_inc[ADDR_W-1:0];
            if (sel_q == '0) begin
              acc_d = '0;
            end else if (addr_inc == r_len) begin
              acc_d   = ACC_PEAK;
              state_d = FALL;
            end else begin
              acc_d = acc_q + ACC_W'(up_inc);
            end
          end
        end
      end
      FALL: begin
        if (beat) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d = addr_inc[ADDR_W-1:0];
            acc_d  = (acc_q < ACC_W'(down_dec)) ? '0 : acc_q - ACC_W'(down_dec);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
    end
  end

  // Status flags are registered from the next state, keeping i_wready off any output path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= (state_d == RISE) || (state_d == FALL);
      done_q   <= (state_d == DONE);
    end
  end

  assign o_we    = active_q;
  assign o_busy  = active_q;
  assign o_done  = done_q;
  assign o_waddr = addr_q;
  assign o_wdata = acc_q[ACC_W-1 -: DATA_W];

endmodule

// File: tb/tb_sawtooth_lut_writer.sv
// Directed bench for sawtooth_lut_writer: captures each written table and
// compares it against hand-computed points and a closed-form sawtooth model.
module tb_sawtooth_lut_writer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [3:0]  i_sel;
  logic        i_wready;
  logic        o_we;
  logic [9:0]  o_waddr;
  logic [15:0] o_wdata;
  logic        o_busy;
  logic        o_done;

  sawtooth_lut_writer #(
    .ADDR_W (10),
    .DATA_W (16)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_sel    (i_sel),
    .i_wready (i_wready),
    .o_we     (o_we),
    .o_waddr  (o_waddr),
    .o_wdata  (o_wdata),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [1024];
  int beats, done_cnt, done_cyc, seq_err, hold_err, stall_cnt;
  logic first_we, first_busy;
  logic [9:0]  first_addr;
  logic [15:0] first_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Closed-form sawtooth value at one address, independent of the accumulator walk.
  function automatic int model_sample(input int sel, input int addr);
    int s, r, up, dn, a;
    s = (sel > 10) ? 0 : sel;
    if (s == 0) return 0;
    r  = (s * 1024 + 5) / 10;
    up = 16776960 / r;
    if (addr < r) return (addr * up) >> 8;
    if (addr == r) return 65535;
    dn = 16776960 / (1024 - r);
    a  = 16776960 - (addr - r) * dn;
    if (a < 0) a = 0;
    return a >> 8;
  endfunction

  task automatic run_table(input int sel, input bit rand_ready, input int poke_addr, input int rst_addr);
    int exp_addr;
    bit stalled, poked;
    logic [9:0]  h_addr;
    logic [15:0] h_data;
    beats = 0; done_cnt = 0; done_cyc = 0; seq_err = 0; hold_err = 0; stall_cnt = 0;
    exp_addr = 0; stalled = 0; poked = 0; h_addr = '0; h_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
    @(negedge i_clk);
    i_sel    = 4'(sel);
    i_start  = 1'b1;
    i_wready = 1'b1;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (cyc == 1) begin
        first_we = o_we; first_busy = o_busy; first_addr = o_waddr; first_data = o_wdata;
      end
      if (stalled && (o_we !== 1'b1 || o_waddr !== h_addr || o_wdata !== h_data)) hold_err++;
      if (o_busy !== o_we) seq_err++;
      if (o_done && o_we) seq_err++;
      if (o_done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) return;
      if (o_we && rst_addr >= 0 && int'(o_waddr) == rst_addr) begin
        i_rst_n = 1'b0;
        #1;
        return;
      end
      if (o_we && poke_addr >= 0 && !poked && int'(o_waddr) == poke_addr) begin
        i_start = 1'b1;
        i_sel   = 4'd2;
        poked   = 1'b1;
      end
      i_wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled  = 1'b0;
      if (o_we && i_wready) begin
        if (int'(o_waddr) != exp_addr) seq_err++;
        mem[o_waddr] = o_wdata;
        exp_addr++;
        beats++;
      end else if (o_we) begin
        stalled = 1'b1;
        h_addr  = o_waddr;
        h_data  = o_wdata;
        stall_cnt++;
      end
    end
  endtask

  task automatic verify_table(input string tag, input int sel);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (int'(mem[i]) != model_sample(sel, i)) bad++;
    check({tag, "_beats"}, 32'(beats), 32'd1024);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    check({tag, "_hold_err"}, 32'(hold_err), 32'd0);
    check({tag, "_model_err"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int decreases, nonzero;
    i_rst_n = 1'b0; i_start = 1'b0; i_sel = '0; i_wready = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_we", 32'(o_we), 32'd0);
    check("reset_waddr", 32'(o_waddr), 32'd0);
    check("reset_wdata", 32'(o_wdata), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    i_rst_n = 1'b1;

    run_table(5, 1'b0, -1, -1);
    check("start_we", 32'(first_we), 32'd1);
    check("start_busy", 32'(first_busy), 32'd1);
    check("start_addr", 32'(first_addr), 32'd0);
    check("start_data", 32'(first_data), 32'd0);
    check("s5_a0", 32'(mem[0]), 32'h0000);
    check("s5_a1", 32'(mem[1]), 32'h007F);
    check("s5_a511", 32'(mem[511]), 32'hFF7E);
    check("s5_a512", 32'(mem[512]), 32'hFFFF);
    check("s5_a513", 32'(mem[513]), 32'hFF7F);
    check("s5_a1023", 32'(mem[1023]), 32'h0080);
    check("s5_done_cycle", 32'(done_cyc), 32'd1025);
    verify_table("s5", 5);

    run_table(10, 1'b0, -1, -1);
    decreases = 0;
    for (int i = 1; i < 1024; i++) if (mem[i] < mem[i-1]) decreases++;
    check("s10_decreases", 32'(decreases), 32'd0);
    check("s10_a1023", 32'(mem[1023]), 32'hFFBC);
    check("s10_done_cycle", 32'(done_cyc), 32'd1025);
    verify_table("s10", 10);

    run_table(0, 1'b0, -1, -1);
    nonzero = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != 16'h0000) nonzero++;
    check("s0_nonzero", 32'(nonzero), 32'd0);
    verify_table("s0", 0);

    run_table(13, 1'b0, -1, -1);
    nonzero = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != 16'h0000) nonzero++;
    check("s13_nonzero", 32'(nonzero), 32'd0);
    verify_table("s13", 13);

    run_table(3, 1'b1, -1, -1);
    check("s3_stalls_seen", 32'(stall_cnt > 0), 32'd1);
    check("s3_a306", 32'(mem[306]), 32'hFF29);
    check("s3_a307_peak", 32'(mem[307]), 32'hFFFF);
    check("s3_a308", 32'(mem[308]), 32'hFFA3);
    verify_table("s3", 3);

    run_table(7, 1'b0, 200, -1);
    check("busy_start_done_cycle", 32'(done_cyc), 32'd1025);
    verify_table("s7_poke", 7);

    run_table(5, 1'b0, -1, 600);
    check("midrst_we", 32'(o_we), 32'd0);
    check("midrst_waddr", 32'(o_waddr), 32'd0);
    check("midrst_wdata", 32'(o_wdata), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_table(1, 1'b0, -1, -1);
    check("s1_a1", 32'(mem[1]), 32'h0282);
    check("s1_a101", 32'(mem[101]), 32'hFD7C);
    check("s1_a102_peak", 32'(mem[102]), 32'hFFFF);
    check("s1_a103", 32'(mem[103]), 32'hFFB7);
    check("s1_a1023", 32'(mem[1023]), 32'h0048);
    verify_table("s1", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
